// File: rtl/biassram_r_if.sv
// Bias SRAM read-side bundle: writer handshake, PE-stage group control,
// SRAM_0 read port and the parallel bias bank output.
interface biassram_r_if #(
  parameter int ADDR_CNT_BITS  = 9,
  parameter int BIAS_SRAM_WLEN = 32,
  parameter int BIAS_GROUP     = 8
);
  // Handshake with the bias SRAM write controller
  logic                                bias_rd1st_start;
  logic                                bias_rd1st_busy;
  logic                                bias_rd1st_done;
  // Group stepping from the PE/output stage
  logic                                bias_next;
  logic                                bias_layer_end;
  // Bias SRAM_0 read port
  logic                                cen_biasr_0;
  logic                                wen_biasr_0;
  logic [ADDR_CNT_BITS-1:0]            addr_biasr_0;
  logic [BIAS_SRAM_WLEN-1:0]           dout_biasr_0;
  // Parallel bias group
  logic [BIAS_GROUP*BIAS_SRAM_WLEN-1:0] bias_group_dout;
  logic                                bias_group_valid;

  // The read engine
  modport slave (
    input  bias_rd1st_start, bias_next, bias_layer_end, dout_biasr_0,
    output bias_rd1st_busy, bias_rd1st_done, cen_biasr_0, wen_biasr_0,
           addr_biasr_0, bias_group_dout, bias_group_valid
  );

  // The surroundings: writer, PE stage and SRAM
  modport master (
    output bias_rd1st_start, bias_next, bias_layer_end, dout_biasr_0,
    input  bias_rd1st_busy, bias_rd1st_done, cen_biasr_0, wen_biasr_0,
           addr_biasr_0, bias_group_dout, bias_group_valid
  );
endinterface

// File: rtl/biassram_r.sv
// Bias SRAM read engine: loads BIAS_GROUP consecutive bias words from SRAM_0
// into a register bank and presents them in parallel until the PE stage asks
// for the next group or ends the layer.
module biassram_r #(
  parameter int BIAS_ST_LENGTH = 64,
  parameter int BIAS_GROUP     = 8,
  parameter int ADDR_CNT_BITS  = 9,
  parameter int BIAS_SRAM_WLEN = 32
) (
  input  logic         clk,
  input  logic         reset,
  biassram_r_if.slave  bus
);

  localparam int CNT_W = (BIAS_GROUP > 1) ? $clog2(BIAS_GROUP) : 1;
  localparam logic [CNT_W-1:0]         CNT_LAST   = CNT_W'(BIAS_GROUP - 1);
  localparam logic [ADDR_CNT_BITS-1:0] GROUP_STEP = ADDR_CNT_BITS'(BIAS_GROUP);
  localparam logic [ADDR_CNT_BITS-1:0] BASE_WRAP  = ADDR_CNT_BITS'(BIAS_ST_LENGTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_HOLD
  } state_e;

  state_e                    state_q, state_d;
  logic [ADDR_CNT_BITS-1:0]  base_q, base_d;
  logic [ADDR_CNT_BITS-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          cap_idx_q, cap_idx_d;
  logic                      cap_en_q, cap_en_d;
  logic                      rd1st_q, rd1st_d;
  logic                      done_q, done_d;
  logic [BIAS_SRAM_WLEN-1:0] bank_q [BIAS_GROUP];
  logic [BIAS_SRAM_WLEN-1:0] bank_d [BIAS_GROUP];

  logic [ADDR_CNT_BITS-1:0]             rd_addr;
  logic [ADDR_CNT_BITS-1:0]             base_inc;
  logic [BIAS_GROUP*BIAS_SRAM_WLEN-1:0] bank_flat;

  assign rd_addr  = base_q + ADDR_CNT_BITS'(cnt_q);
  assign base_inc = base_q + GROUP_STEP;

  // Next-state logic: sequence one group load and react to next/layer_end in HOLD
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    rd1st_d = rd1st_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.bias_rd1st_start) begin
          base_d  = '0;
          rd1st_d = 1'b1;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // Only a start-initiated load reports completion to the writer
        done_d  = rd1st_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (bus.bias_layer_end) begin
          base_d  = '0;
          state_d = S_IDLE;
        end else if (bus.bias_next) begin
          rd1st_d = 1'b0;
          base_d  = (base_inc == BASE_WRAP) ? '0 : base_inc;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: remember the issued slot, capture SRAM data one cycle later, hold last address
  always_comb begin
    cap_en_d  = (state_q == S_READ);
    cap_idx_d = cnt_q;
    addr_d    = (state_q == S_READ) ? rd_addr : addr_q;
    bank_d    = bank_q;
    if (cap_en_q) begin
      bank_d[cap_idx_q] = bus.dout_biasr_0;
    end
  end

  // State and datapath registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      cap_idx_q <= '0;
      cap_en_q  <= 1'b0;
      rd1st_q   <= 1'b0;
      done_q    <= 1'b0;
      // NOTE: the bank is a small flop array, not SRAM, so it is cleared on reset like any register.
      for (int k = 0; k < BIAS_GROUP; k++) begin
        bank_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      cap_idx_q <= cap_idx_d;
      cap_en_q  <= cap_en_d;
      rd1st_q   <= rd1st_d;
      done_q    <= done_d;
      bank_q    <= bank_d;
    end
  end

  // Flatten the bank so word k sits on bits [32k+31:32k]
  always_comb begin
    bank_flat = '0;
    for (int k = 0; k < BIAS_GROUP; k++) begin
      bank_flat[k*BIAS_SRAM_WLEN +: BIAS_SRAM_WLEN] = bank_q[k];
    end
  end

  assign bus.cen_biasr_0      = (state_q != S_READ);
  assign bus.wen_biasr_0      = 1'b1;
  assign bus.addr_biasr_0     = (state_q == S_READ) ? rd_addr : addr_q;
  assign bus.bias_rd1st_busy  = (state_q == S_READ) | (state_q == S_DRAIN);
  assign bus.bias_rd1st_done  = done_q;
  assign bus.bias_group_valid = (state_q == S_HOLD);
  assign bus.bias_group_dout  = bank_flat;

endmodule

// File: tb/tb_biassram_r.sv
// Bench for biassram_r: behavioural SRAM with one-cycle read latency plus a
// reference model (base pointer arithmetic and array lookups) for each group.
module tb_biassram_r;
  localparam int G   = 8;
  localparam int LEN = 64;
  localparam int AW  = 9;
  localparam int WL  = 32;
  localparam int DW  = G * WL;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  biassram_r_if #(.ADDR_CNT_BITS(AW), .BIAS_SRAM_WLEN(WL), .BIAS_GROUP(G)) bus ();

  biassram_r #(
    .BIAS_ST_LENGTH(LEN),
    .BIAS_GROUP    (G),
    .ADDR_CNT_BITS (AW),
    .BIAS_SRAM_WLEN(WL)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Behavioural SRAM: data for a cen-low cycle appears in the following cycle
  logic [WL-1:0] mem [1 << AW];
  int unsigned   reads = 0;
  always @(posedge clk) begin
    if (bus.cen_biasr_0 === 1'b0) begin
      bus.dout_biasr_0 <= mem[bus.addr_biasr_0];
      reads            <= reads + 1;
    end
  end

  int checks   = 0;
  int failures = 0;
  int model_base;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference group: the G words stored from base upward
  function automatic logic [DW-1:0] exp_group(input int b);
    logic [DW-1:0] g;
    g = '0;
    for (int k = 0; k < G; k++) g[k*WL +: WL] = mem[b + k];
    return g;
  endfunction

  task automatic randomize_mem();
    for (int k = 0; k < LEN; k++) mem[k] = $urandom;
  endtask

  // Caller has just raised start or next at a negedge; walk the whole load.
  task automatic run_load(input string nm, input int base, input bit exp_done,
                          input bit hold_start, input int repulse_at);
    int unsigned r0;
    r0 = reads;
    for (int c = 1; c <= G; c++) begin
      @(negedge clk);
      if (!hold_start) bus.bias_rd1st_start = (c == repulse_at);
      bus.bias_next      = 1'b0;
      bus.bias_layer_end = 1'b0;
      check($sformatf("%s rd%0d busy", nm, c), bus.bias_rd1st_busy, 1'b1);
      check($sformatf("%s rd%0d cen", nm, c), bus.cen_biasr_0, 1'b0);
      check($sformatf("%s rd%0d wen", nm, c), bus.wen_biasr_0, 1'b1);
      check($sformatf("%s rd%0d addr", nm, c), bus.addr_biasr_0, base + c - 1);
      check($sformatf("%s rd%0d valid", nm, c), bus.bias_group_valid, 1'b0);
    end
    @(negedge clk);
    if (!hold_start) bus.bias_rd1st_start = 1'b0;
    check($sformatf("%s drain busy", nm), bus.bias_rd1st_busy, 1'b1);
    check($sformatf("%s drain cen", nm), bus.cen_biasr_0, 1'b1);
    check($sformatf("%s drain valid", nm), bus.bias_group_valid, 1'b0);
    check($sformatf("%s drain done", nm), bus.bias_rd1st_done, 1'b0);
    @(negedge clk);
    check($sformatf("%s hold valid", nm), bus.bias_group_valid, 1'b1);
    check($sformatf("%s hold done", nm), bus.bias_rd1st_done, exp_done);
    check($sformatf("%s hold busy", nm), bus.bias_rd1st_busy, 1'b0);
    check($sformatf("%s hold cen", nm), bus.cen_biasr_0, 1'b1);
    check($sformatf("%s hold addr", nm), bus.addr_biasr_0, base + G - 1);
    check($sformatf("%s hold data", nm), bus.bias_group_dout, exp_group(base));
    check($sformatf("%s read count", nm), reads - r0, G);
  endtask

  // Pulse layer_end from HOLD and confirm the group is released
  task automatic go_idle(input string nm);
    bus.bias_layer_end = 1'b1;
    @(negedge clk);
    bus.bias_layer_end = 1'b0;
    check($sformatf("%s idle valid", nm), bus.bias_group_valid, 1'b0);
    check($sformatf("%s idle busy", nm), bus.bias_rd1st_busy, 1'b0);
  endtask

  initial begin
    int unsigned r0;
    bus.bias_rd1st_start = 1'b0;
    bus.bias_next        = 1'b0;
    bus.bias_layer_end   = 1'b0;
    bus.dout_biasr_0     = '0;
    reset                = 1'b1;
    for (int k = 0; k < (1 << AW); k++) mem[k] = 32'h1000_0000 + k;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst busy", bus.bias_rd1st_busy, 1'b0);
    check("rst done", bus.bias_rd1st_done, 1'b0);
    check("rst valid", bus.bias_group_valid, 1'b0);
    check("rst cen", bus.cen_biasr_0, 1'b1);
    check("rst wen", bus.wen_biasr_0, 1'b1);
    check("rst addr", bus.addr_biasr_0, 0);
    check("rst bank", bus.bias_group_dout, '0);
    reset = 1'b0;
    @(negedge clk);

    // First start-initiated load from address 0
    bus.bias_rd1st_start = 1'b1;
    model_base = 0;
    run_load("first", model_base, 1'b1, 1'b0, 0);
    @(negedge clk);
    check("first done once", bus.bias_rd1st_done, 1'b0);
    check("first valid kept", bus.bias_group_valid, 1'b1);
    go_idle("le1");

    // Start held high through the load and past done: one load only
    bus.bias_rd1st_start = 1'b1;
    r0 = reads;
    run_load("held", 0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("held post%0d done", i), bus.bias_rd1st_done, 1'b0);
      check($sformatf("held post%0d valid", i), bus.bias_group_valid, 1'b1);
      check($sformatf("held post%0d busy", i), bus.bias_rd1st_busy, 1'b0);
    end
    check("held total reads", reads - r0, G);
    bus.bias_rd1st_start = 1'b0;

    // Walk all groups with next, then wrap back to base 0
    model_base = 0;
    for (int n = 1; n <= LEN / G; n++) begin
      bus.bias_next = 1'b1;
      model_base = (model_base + G) % LEN;
      run_load($sformatf("next%0d", n), model_base, 1'b0, 1'b0, 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check($sformatf("next%0d stable", n), bus.bias_group_valid, 1'b1);
      end
    end
    check("wrap data", bus.bias_group_dout, {32'h1000_0007, 32'h1000_0006, 32'h1000_0005,
          32'h1000_0004, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000});

    // next and layer_end together: layer_end wins, no reads
    randomize_mem();
    bus.bias_next = 1'b1;
    model_base = G;
    run_load("pre_both", model_base, 1'b0, 1'b0, 0);
    bus.bias_next      = 1'b1;
    bus.bias_layer_end = 1'b1;
    r0 = reads;
    @(negedge clk);
    bus.bias_next      = 1'b0;
    bus.bias_layer_end = 1'b0;
    check("both valid", bus.bias_group_valid, 1'b0);
    check("both busy", bus.bias_rd1st_busy, 1'b0);
    check("both cen", bus.cen_biasr_0, 1'b1);
    repeat (3) @(negedge clk);
    check("both no reads", reads - r0, 0);
    bus.bias_rd1st_start = 1'b1;
    run_load("after_both", 0, 1'b1, 1'b0, 0);
    go_idle("le2");

    // Reset in READ cycle 4
    bus.bias_rd1st_start = 1'b1;
    @(negedge clk);
    bus.bias_rd1st_start = 1'b0;
    repeat (4) @(negedge clk);
    check("mid addr before reset", bus.addr_biasr_0, 4);
    reset = 1'b1;
    #1;
    check("mid rst cen", bus.cen_biasr_0, 1'b1);
    check("mid rst busy", bus.bias_rd1st_busy, 1'b0);
    check("mid rst valid", bus.bias_group_valid, 1'b0);
    check("mid rst bank", bus.bias_group_dout, '0);
    check("mid rst addr", bus.addr_biasr_0, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post rst valid", bus.bias_group_valid, 1'b0);
    bus.bias_rd1st_start = 1'b1;
    run_load("post_rst", 0, 1'b1, 1'b0, 0);
    go_idle("le3");

    // next / layer_end in IDLE and start during READ are ignored
    r0 = reads;
    bus.bias_next = 1'b1;
    @(negedge clk);
    bus.bias_next      = 1'b0;
    bus.bias_layer_end = 1'b1;
    @(negedge clk);
    bus.bias_layer_end = 1'b0;
    repeat (2) @(negedge clk);
    check("idle ign busy", bus.bias_rd1st_busy, 1'b0);
    check("idle ign valid", bus.bias_group_valid, 1'b0);
    check("idle ign cen", bus.cen_biasr_0, 1'b1);
    check("idle ign reads", reads - r0, 0);
    bus.bias_rd1st_start = 1'b1;
    run_load("restart", 0, 1'b1, 1'b0, 3);
    r0 = reads;
    for (int i = 0; i < G + 3; i++) begin
      @(negedge clk);
      check($sformatf("restart hold%0d", i), bus.bias_group_valid, 1'b1);
    end
    check("restart no reload", reads - r0, 0);

    // Randomized mix of next, layer_end+start and idle HOLD cycles
    model_base = 0;
    for (int it = 0; it < 12; it++) begin
      int unsigned op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        randomize_mem();
        bus.bias_next = 1'b1;
        model_base = (model_base + G) % LEN;
        run_load($sformatf("rnd%0d next", it), model_base, 1'b0, 1'b0, 0);
      end else if (op == 1) begin
        go_idle($sformatf("rnd%0d", it));
        randomize_mem();
        bus.bias_rd1st_start = 1'b1;
        model_base = 0;
        run_load($sformatf("rnd%0d start", it), model_base, 1'b1, 1'b0, 0);
      end else begin
        repeat ($urandom_range(1, 3)) begin
          bus.bias_rd1st_start = 1'($urandom_range(0, 1));
          @(negedge clk);
          check($sformatf("rnd%0d hold valid", it), bus.bias_group_valid, 1'b1);
          check($sformatf("rnd%0d hold data", it), bus.bias_group_dout, exp_group(model_base));
        end
        bus.bias_rd1st_start = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
